// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single data-memory port (core pipeline vs DMA/debug).
// Default build: fixed core priority with DMA starvation bound; define DMEM_ARB_RR_EN for round-robin on conflict.
module dmem_port_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     core_req,
  input  logic                     core_we,
  input  logic [2:0]               core_funct3,
  input  logic [ADDRESS_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0]    core_wdata,
  output logic                     core_gnt,
  output logic                     core_rvalid,
  output logic [DATA_WIDTH-1:0]    core_rdata,
  output logic                     core_err,

  input  logic                     dma_req,
  input  logic                     dma_we,
  input  logic [2:0]               dma_funct3,
  input  logic [ADDRESS_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0]    dma_wdata,
  output logic                     dma_gnt,
  output logic                     dma_rvalid,
  output logic [DATA_WIDTH-1:0]    dma_rdata,
  output logic                     dma_err,

  output logic                     mem_write_e,
  output logic [2:0]               mem_funct3,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  logic                  core_pick;
  logic                  dma_pick;
  logic                  sel_we;
  logic                  aligned;
  logic [DATA_WIDTH-1:0] load_data;

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000, 3'b100: ok = 1'b1;
      3'b001, 3'b101: ok = ~a[0];
      3'b010:         ok = (a == 2'b00);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef DMEM_ARB_RR_EN
  typedef enum logic {OWNER_CORE = 1'b0, OWNER_DMA = 1'b1} owner_t;
  owner_t last_owner;

  // On conflict the requester that did not win last conflict goes first.
  always_comb begin
    core_pick = core_req && (!dma_req || (last_owner == OWNER_DMA));
    dma_pick  = dma_req && !core_pick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWNER_CORE;
    end else if (core_req && dma_req) begin
      last_owner <= dma_gnt ? OWNER_DMA : OWNER_CORE;
    end
  end
`else
  logic [3:0] starve_cnt;
  logic       starve_hit;

  // Core loses only when DMA is still asking and has waited its limit.
  always_comb begin
    starve_hit = (starve_cnt >= 4'(STARVE_LIMIT));
    core_pick  = core_req && !(dma_req && starve_hit);
    dma_pick   = dma_req && !core_pick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!dma_req || dma_gnt) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  always_comb begin
    core_gnt = rst_n && core_pick;
    dma_gnt  = rst_n && dma_pick;

    if (dma_gnt) begin
      sel_we     = dma_we;
      mem_funct3 = dma_funct3;
      mem_addr   = dma_addr;
      mem_wdata  = dma_wdata;
    end else begin
      sel_we     = core_we;
      mem_funct3 = core_funct3;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
    end

    aligned     = is_aligned(mem_funct3, mem_addr[1:0]);
    mem_write_e = (core_gnt || dma_gnt) && sel_we && aligned;
    load_data   = (aligned && !sel_we) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rvalid <= 1'b0;
      core_err    <= 1'b0;
      core_rdata  <= '0;
      dma_rvalid  <= 1'b0;
      dma_err     <= 1'b0;
      dma_rdata   <= '0;
    end else begin
      core_rvalid <= core_gnt;
      core_err    <= core_gnt && !aligned;
      dma_rvalid  <= dma_gnt;
      dma_err     <= dma_gnt && !aligned;
      if (core_gnt) core_rdata <= load_data;
      if (dma_gnt)  dma_rdata  <= load_data;
    end
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (write enable, funct3, address, write data, asynchronous read data) between two requesters: the pipeline memory stage (core) and a DMA/debug master (dma).
- Arbitrates one access per cycle and returns load data registered one cycle later to the winning requester.
- Rejects misaligned accesses before they reach memory.
- Bounds DMA waiting time with a starvation counter.

Parameters:
- ADDRESS_WIDTH, 32, address width of both requesters and the memory port.
- DATA_WIDTH, 32, data width.
- STARVE_LIMIT, 4, number of consecutive denied dma cycles after which dma wins over core; must be 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- core_req  input  1  core requests an access this cycle.
- core_we  input  1  1 = store, 0 = load.
- core_funct3  input  3  RV32 load/store funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
- core_addr  input  ADDRESS_WIDTH  byte address.
- core_wdata  input  DATA_WIDTH  store data.
- core_gnt  output  1  combinational; access accepted this cycle.
- core_rvalid  output  1  registered; completion pulse one cycle after grant.
- core_rdata  output  DATA_WIDTH  registered load data.
- core_err  output  1  registered; misaligned-access pulse, coincident with core_rvalid.
- dma_req, dma_we, dma_funct3, dma_addr, dma_wdata  inputs  same widths as the core_ equivalents.
- dma_gnt, dma_rvalid, dma_rdata, dma_err  outputs  same widths and semantics as the core_ equivalents.
- mem_write_e  output  1  memory write enable (combinational).
- mem_funct3  output  3  funct3 to memory.
- mem_addr  output  ADDRESS_WIDTH  address to memory.
- mem_wdata  output  DATA_WIDTH  write data to memory.
- mem_rdata  input  DATA_WIDTH  asynchronous read data from memory.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered outputs go to 0: rvalid, rdata and err for both requesters.
  - starve_cnt goes to 0.
  - Both gnt outputs and mem_write_e are forced to 0 while rst_n is low.
- Grant rule, fixed priority (default build):
  - If core_req and starve_cnt < STARVE_LIMIT, core_gnt = 1.
  - Else if dma_req, dma_gnt = 1.
  - If starve_cnt == STARVE_LIMIT and dma_req, dma_gnt = 1 and core_gnt = 0; core must hold its request.
  - At most one gnt is high per cycle.
- Starvation counter (4 bits):
  - Increments, saturating at STARVE_LIMIT, on each cycle with dma_req && !dma_gnt.
  - Clears on dma_gnt or on !dma_req.
- Memory mux:
  - mem_funct3, mem_addr and mem_wdata come from the granted requester; when neither is granted they come from core.
  - mem_write_e = gnt && we && aligned.
- Alignment:
  - Halfword accesses (001/101) require addr[0] = 0.
  - Word accesses (010) require addr[1:0] = 00.
  - Byte accesses are always aligned.
  - An unsupported funct3 (011, 110, 111) is treated as misaligned.
  - A misaligned access is still granted, but memory is not written.
- Completion, one cycle after a grant:
  - The granted requester's rvalid = 1 and err = !aligned.
  - rdata = mem_rdata sampled in the grant cycle for an aligned load; 0 for a store or an error.
  - rvalid is a single-cycle pulse per grant; back-to-back grants give back-to-back pulses.
  - rdata holds its value until the next completion.
- Simultaneous events: new grants in the same cycle as a completion are legal; there is no internal queue.
- Reset mid-access: a grant in the cycle rst_n falls produces no completion and no memory write.

Optional Feature:
- DMEM_ARB_RR_EN defined:
  - starve_cnt and STARVE_LIMIT are unused.
  - A 1-bit last_owner register (reset 0 = core) selects the winner on conflict: the requester that was not last_owner wins.
  - last_owner updates to the winner only on a conflict cycle.
  - A single requester is always granted.
- DMEM_ARB_RR_EN undefined: fixed priority with the starvation counter as above.

Test Plan:
- Core-only load: core_req=1, we=0, funct3=010, addr=0x8, mem_rdata=0xDEADBEEF -> core_gnt same cycle; next cycle core_rvalid=1, core_rdata=0xDEADBEEF, core_err=0.
- Misaligned: core sh (funct3=001) at addr 0x5 -> mem_write_e=0; next cycle core_rvalid=1, core_err=1, core_rdata=0.
- Starvation: core_req and dma_req held high continuously, STARVE_LIMIT=4 -> core granted cycles 0-3, dma granted cycle 4, starve_cnt back to 0, core granted cycle 5.
- DMA store: dma_req=1, we=1, funct3=000, addr=0x3, wdata=0xA5 with core idle -> dma_gnt=1, mem_write_e=1, mem_addr=0x3; next cycle dma_rvalid=1.
- Reset mid-access: rst_n low in the grant cycle -> no rvalid pulse next cycle; all outputs 0; first access after reset completes normally.
- RR build (DMEM_ARB_RR_EN): both requesting continuously -> grants alternate dma, core, dma, core starting with dma.
